seg7_scan_driver: RTL and testbench

//  Time-multiplexed driver for an N-digit common-anode seven-segment display.

---
 rtl/seg7_scan_driver_if.sv | 33 +++
 rtl/seg7_scan_driver.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bundle of the signals between the datapath and the seven-segment scan driver.
//   hex_val     packed hex digits, digit i = hex_val[4*i+3:4*i]
//   digit_en    per-digit display enable
//   flash_mask  per-digit flash enable
//   dp_in       per-digit decimal point request
//   seg         active-low segments, seg[0]=a ... seg[6]=g
//   dp          active-low decimal point
//   an          active-low anode selects, an[i] = digit i
//   frame_start one-clock pulse when the driver latches a new frame
// master: the datapath side (drives digit data, observes display pins).
// slave : the scan driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] hex_val;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   flash_mask;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [0:6]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_start;

    modport master (
        output hex_val, digit_en, flash_mask, dp_in,
        input  seg, dp, an, frame_start
    );

    modport slave (
        input  hex_val, digit_en, flash_mask, dp_in,
        output seg, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// One digit is driven per slot of SCAN_DIV clocks; the first BLANK_CYC clocks
// of every slot keep all anodes off so the previous digit cannot ghost.
// Digit data is latched into shadow registers once per frame so a frame is
// never torn by inputs changing mid-scan.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of seg7_scan_driver_if (digit data in, display pins out)
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 500,
    parameter int FLASH_FRAMES = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg7_scan_driver_if.slave      bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYC);

    // Hex digit to active-low abcdefg pattern; bit 0 of the result is segment a.
    function automatic logic [0:6] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    logic [CW-1:0]           scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [FW-1:0]           flash_cnt_q, flash_cnt_d;
    logic                    flash_phase_q, flash_phase_d;
    logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [NUM_DIGITS-1:0]   fm_q, fm_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_end;
    logic [3:0]              digit;

    always_comb begin
        scan_cnt_d    = scan_cnt_q + 1'b1;
        idx_d         = idx_q;
        frame_end     = 1'b0;
        flash_cnt_d   = flash_cnt_q;
        flash_phase_d = flash_phase_q;
        hex_d         = hex_q;
        en_d          = en_q;
        fm_d          = fm_q;
        dpm_d         = dpm_q;
        seg_d         = '1;
        dp_d          = 1'b1;
        an_d          = '1;
        digit         = hex_q[{idx_q, 2'b00} +: 4];

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d     = '0;
                frame_end = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Shadows and flash timing only move on the last clock of a frame.
        if (frame_end) begin
            hex_d = bus.hex_val;
            en_d  = bus.digit_en;
            fm_d  = bus.flash_mask;
            dpm_d = bus.dp_in;
            if (flash_cnt_q == FLASH_LAST) begin
                flash_cnt_d   = '0;
                flash_phase_d = ~flash_phase_q;
            end else begin
                flash_cnt_d = flash_cnt_q + 1'b1;
            end
        end
        frame_start_d = frame_end;

        // Only one anode bit can ever be cleared, and only outside the blanking gap.
        if (scan_cnt_q >= BLANK_END && en_q[idx_q] && !(fm_q[idx_q] && flash_phase_q)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph(digit);
            dp_d        = ~dpm_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b0;
            hex_q         <= '0;
            en_q          <= '0;
            fm_q          <= '0;
            dpm_q         <= '0;
            seg_q         <= '1;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            hex_q         <= hex_d;
            en_q          <= en_d;
            fm_q          <= fm_d;
            dpm_q         <= dpm_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, FLASH_FRAMES=2.
// The stimulus pushes the expected lit cycles of each frame into a queue when
// the frame starts; a monitor pops one entry per cycle in which an anode is on.
module tb_seg7_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    seg7_scan_driver_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (4),
        .BLANK_CYC   (1),
        .FLASH_FRAMES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   sb_en = 1'b0;
    logic [11:0] exp_q[$];

    // Each lit slot spans three clocks (four per slot minus one blank clock).
    task automatic push_slot(input logic [3:0] an_e, input logic [0:6] seg_e, input logic dp_e);
        repeat (3) exp_q.push_back({an_e, seg_e, dp_e});
    endtask

    task automatic set_in(input logic [15:0] h, input logic [3:0] en, input logic [3:0] fm,
                          input logic [3:0] dpm);
        bus.hex_val    = h;
        bus.digit_en   = en;
        bus.flash_mask = fm;
        bus.dp_in      = dpm;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_start && n < 40);
        n_cmp++;
        if (!bus.frame_start) begin
            n_bad++;
            $display("FAIL %s_timeout: no frame_start within %0d cycles, required within 40", tag, n);
        end
    endtask

    task automatic check_drained(input string tag);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d expected lit cycles never seen, required 0", tag, exp_q.size());
        end
    endtask

    // Monitor: one-hot anode check, frame period check, scoreboard pop on lit cycles.
    int cyc = 0;
    int last_fs = 0;
    bit have_fs = 1'b0;
    always @(negedge clk) begin
        int zeros;
        logic [11:0] e;
        logic [11:0] got;
        cyc++;
        if (!rst_n) begin
            have_fs = 1'b0;
        end else begin
            zeros = 0;
            for (int i = 0; i < 4; i++) if (!bus.an[i]) zeros++;
            n_cmp++;
            if (zeros > 1) begin
                n_bad++;
                $display("FAIL onehot_an: an=%b has %0d low bits, required at most 1", bus.an, zeros);
            end
            if (bus.frame_start) begin
                if (have_fs) begin
                    n_cmp++;
                    if (cyc - last_fs != 16) begin
                        n_bad++;
                        $display("FAIL frame_period: %0d clocks between frame_start, required 16", cyc - last_fs);
                    end
                end
                have_fs = 1'b1;
                last_fs = cyc;
            end
            if (sb_en && bus.an != 4'hF) begin
                got = {bus.an, bus.seg, bus.dp};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_lit: an=%b seg=%b dp=%b, required all off", bus.an, bus.seg, bus.dp);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL slot: an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                                 got[11:8], got[7:1], got[0], e[11:8], e[7:1], e[0]);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        set_in(16'h0, 4'h0, 4'h0, 4'h0);
        #1 rst_n = 1'b0;

        // Held in reset with toggling inputs: everything stays off.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            n_cmp++;
            if (bus.seg !== 7'b1111111 || bus.dp !== 1'b1 || bus.an !== 4'b1111 || bus.frame_start !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: seg=%b dp=%b an=%b fs=%b, required 1111111 1 1111 0",
                         bus.seg, bus.dp, bus.an, bus.frame_start);
            end
        end

        // Frame 1 shows the cleared shadows (dark); frame 2 shows 1A3F.
        @(negedge clk);
        set_in(16'h1A3F, 4'b1111, 4'b0000, 4'b0000);
        sb_en = 1'b1;
        rst_n = 1'b1;

        wait_frame("f2");
        push_slot(4'b1110, 7'b0111000, 1'b1);
        push_slot(4'b1101, 7'b0000110, 1'b1);
        push_slot(4'b1011, 7'b0001000, 1'b1);
        push_slot(4'b0111, 7'b1001111, 1'b1);
        repeat (5) @(negedge clk);
        set_in(16'h0000, 4'b1111, 4'b0000, 4'b0000);

        wait_frame("f3");
        for (int k = 0; k < 4; k++) push_slot(~(4'b0001 << k), 7'b0000001, 1'b1);
        repeat (5) @(negedge clk);
        set_in(16'h8765, 4'b1111, 4'b0100, 4'b0000);

        // Flash phase by frame: 4 off, 5 on, 6 on, 7 off, 8 off.
        wait_frame("f4");
        push_slot(4'b1110, 7'b0100100, 1'b1);
        push_slot(4'b1101, 7'b0100000, 1'b1);
        push_slot(4'b0111, 7'b0000000, 1'b1);
        for (int f = 5; f <= 6; f++) begin
            wait_frame("f5_6");
            push_slot(4'b1110, 7'b0100100, 1'b1);
            push_slot(4'b1101, 7'b0100000, 1'b1);
            push_slot(4'b1011, 7'b0001111, 1'b1);
            push_slot(4'b0111, 7'b0000000, 1'b1);
        end
        for (int f = 7; f <= 8; f++) begin
            wait_frame("f7_8");
            push_slot(4'b1110, 7'b0100100, 1'b1);
            push_slot(4'b1101, 7'b0100000, 1'b1);
            push_slot(4'b0111, 7'b0000000, 1'b1);
        end
        repeat (5) @(negedge clk);
        set_in(16'hCDE9, 4'b0101, 4'b0000, 4'b0001);

        wait_frame("f9");
        push_slot(4'b1110, 7'b0000100, 1'b0);
        push_slot(4'b1011, 7'b1000010, 1'b1);
        repeat (5) @(negedge clk);
        set_in(16'h2B4C, 4'b1111, 4'b0000, 4'b1010);

        wait_frame("f10");
        push_slot(4'b1110, 7'b0110001, 1'b1);
        push_slot(4'b1101, 7'b1001100, 1'b0);
        push_slot(4'b1011, 7'b1100000, 1'b1);
        push_slot(4'b0111, 7'b0010010, 1'b0);
        repeat (5) @(negedge clk);
        set_in(16'hFFFF, 4'b0000, 4'b0000, 4'b1111);

        wait_frame("f11");
        wait_frame("f12");
        check_drained("directed");
        sb_en = 1'b0;

        // Random run: only the one-hot and frame period checks apply.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Make digit 0 lit, then pull reset in the middle of its slot.
        set_in(16'h8888, 4'b1111, 4'b0000, 4'b1111);
        wait_frame("pre_rst_a");
        wait_frame("pre_rst_b");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.an !== 4'b1110) begin
            n_bad++;
            $display("FAIL pre_reset_lit: an=%b, required 1110", bus.an);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.seg !== 7'b1111111 || bus.dp !== 1'b1 || bus.an !== 4'b1111 || bus.frame_start !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: seg=%b dp=%b an=%b fs=%b, required 1111111 1 1111 0",
                     bus.seg, bus.dp, bus.an, bus.frame_start);
        end
        set_in(16'h1A3F, 4'b1111, 4'b0000, 4'b0000);
        repeat (3) @(negedge clk);
        sb_en = 1'b1;
        rst_n = 1'b1;

        // Scan restarts at digit 0: the first frame end lands 16 clocks after release.
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.frame_start && n < 40);
        n_cmp++;
        if (n != 16) begin
            n_bad++;
            $display("FAIL restart_frame: first frame_start after %0d clocks, required 16", n);
        end
        push_slot(4'b1110, 7'b0111000, 1'b1);
        push_slot(4'b1101, 7'b0000110, 1'b1);
        push_slot(4'b1011, 7'b0001000, 1'b1);
        push_slot(4'b0111, 7'b1001111, 1'b1);
        wait_frame("post_rst");
        check_drained("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
